// File: rtl/arb_mux_reg.sv
// CHANNELS-to-1 word multiplexer with an internal round-robin or fixed-priority
// arbiter feeding a single registered output stage (out_valid/out_data/out_sel).
module arb_mux_reg #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 8,
  parameter int ARB_MODE = 0,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_sel,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          dbg_ptr
);

  // Handshake: a word moves on channel i at a rising edge where in_valid[i] and
  // in_ready[i] are both high; the output word is consumed on an edge where
  // out_valid and out_ready are both high. in_ready never depends on in_data.

  logic [SEL_W-1:0]    ptr;
  logic [SEL_W-1:0]    gnt_idx;
  logic [SEL_W-1:0]    ptr_next;
  logic [SEL_W:0]      cand;
  logic                found;
  logic                load;
  logic [CHANNELS-1:0] gnt;
  logic [WIDTH-1:0]    gnt_data;

  assign load    = ~out_valid | out_ready;
  assign dbg_ptr = ptr;

  // Search CHANNELS candidates; in round-robin the start is ptr with an
  // explicit wrap so non-power-of-two channel counts never alias.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (ARB_MODE == 0) begin
        cand = {1'b0, ptr} + (SEL_W+1)'(k);
        if (cand >= (SEL_W+1)'(CHANNELS)) begin
          cand = cand - (SEL_W+1)'(CHANNELS);
        end
      end else begin
        cand = (SEL_W+1)'(k);
      end
      if (!found && in_valid[cand[SEL_W-1:0]]) begin
        found   = 1'b1;
        gnt_idx = cand[SEL_W-1:0];
      end
    end
  end

  always_comb begin
    gnt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      gnt[i] = found && (gnt_idx == SEL_W'(i));
    end
  end

  assign in_ready = (load && !reset) ? gnt : '0;
  assign gnt_data = in_data[gnt_idx*WIDTH +: WIDTH];
  assign ptr_next = (gnt_idx == SEL_W'(CHANNELS-1)) ? '0 : gnt_idx + SEL_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (load) begin
      if (found) begin
        out_valid <= 1'b1;
        out_data  <= gnt_data;
        out_sel   <= gnt_idx;
        if (ARB_MODE == 0) begin
          ptr <= ptr_next;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arb_mux_reg.sv
// Bench for arb_mux_reg: three instances (round-robin x8, fixed-priority x8,
// round-robin x5) checked against a behavioural arbitration model.
module tb_arb_mux_reg;

  logic clk;
  logic reset;

  logic [7:0]   v8, r8, vf, rf;
  logic [255:0] d8, df;
  logic         ov8, ovf, ordy8, ordyf;
  logic [31:0]  od8, odf;
  logic [2:0]   os8, osf, ptr8, ptrf;

  logic [4:0]   v5, r5;
  logic [159:0] d5;
  logic         ov5, ordy5;
  logic [31:0]  od5;
  logic [2:0]   os5, ptr5;

  int checks = 0;
  int errors = 0;

  // reference state
  int          m_ptr8, m_os8, m_osf, m_ptr5, m_os5;
  bit          m_ov8, m_ovf, m_ov5;
  logic [31:0] m_od8, m_odf, m_od5;
  logic [31:0] acc8, accf, acc5;

  arb_mux_reg #(.WIDTH(32), .CHANNELS(8), .ARB_MODE(0)) u_rr8 (
    .clk(clk), .reset(reset), .in_valid(v8), .in_data(d8), .in_ready(r8),
    .out_valid(ov8), .out_data(od8), .out_sel(os8), .out_ready(ordy8), .dbg_ptr(ptr8));

  arb_mux_reg #(.WIDTH(32), .CHANNELS(8), .ARB_MODE(1)) u_fp8 (
    .clk(clk), .reset(reset), .in_valid(vf), .in_data(df), .in_ready(rf),
    .out_valid(ovf), .out_data(odf), .out_sel(osf), .out_ready(ordyf), .dbg_ptr(ptrf));

  arb_mux_reg #(.WIDTH(32), .CHANNELS(5), .ARB_MODE(0)) u_rr5 (
    .clk(clk), .reset(reset), .in_valid(v5), .in_data(d5), .in_ready(r5),
    .out_valid(ov5), .out_data(od5), .out_sel(os5), .out_ready(ordy5), .dbg_ptr(ptr5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int arb(int mode, int n, int ptr, logic [31:0] v);
    for (int k = 0; k < n; k++) begin
      int idx;
      idx = (mode == 1) ? k : (ptr + k) % n;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [31:0] exp_rdy(int mode, int n, int ptr, logic [31:0] v,
                                          bit ov, bit ordy, bit rst);
    int g;
    if (rst || (ov && !ordy)) return 32'd0;
    g = arb(mode, n, ptr, v);
    if (g < 0) return 32'd0;
    return 32'd1 << g;
  endfunction

  task automatic model_clear();
    m_ptr8 = 0; m_os8 = 0; m_osf = 0; m_ptr5 = 0; m_os5 = 0;
    m_ov8 = 0; m_ovf = 0; m_ov5 = 0;
    m_od8 = '0; m_odf = '0; m_od5 = '0;
    acc8 = '0; accf = '0; acc5 = '0;
  endtask

  // advance one clock, updating the model from the inputs presented this cycle
  task automatic tick();
    int g;
    acc8 = '0; accf = '0; acc5 = '0;
    g = arb(0, 8, m_ptr8, {24'b0, v8});
    if (!m_ov8 || ordy8) begin
      if (g >= 0) begin
        m_od8 = d8[g*32 +: 32]; m_os8 = g; m_ov8 = 1; m_ptr8 = (g + 1) % 8; acc8 = 32'd1 << g;
      end else m_ov8 = 0;
    end
    g = arb(1, 8, 0, {24'b0, vf});
    if (!m_ovf || ordyf) begin
      if (g >= 0) begin
        m_odf = df[g*32 +: 32]; m_osf = g; m_ovf = 1; accf = 32'd1 << g;
      end else m_ovf = 0;
    end
    g = arb(0, 5, m_ptr5, {27'b0, v5});
    if (!m_ov5 || ordy5) begin
      if (g >= 0) begin
        m_od5 = d5[g*32 +: 32]; m_os5 = g; m_ov5 = 1; m_ptr5 = (g + 1) % 5; acc5 = 32'd1 << g;
      end else m_ov5 = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    model_clear();
    v8 = '0; vf = '0; v5 = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] w;
    @(negedge clk);
    v8 = 8'hFF;
    #1;
    checks++; if (ov8 !== 1'b0 || od8 !== 32'd0 || os8 !== 3'd0 || ptr8 !== 3'd0) begin
      errors++; $display("FAIL reset_values: ov=%b od=%h sel=%0d ptr=%0d want 0", ov8, od8, os8, ptr8);
    end
    checks++; if (r8 !== 8'h00) begin
      errors++; $display("FAIL reset_ready: got %h want 00", r8);
    end
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    v8 = 8'h10; d8 = {8{$urandom}}; ordy8 = 1'b0;
    tick();
    checks++; if (ov8 !== 1'b1 || os8 !== 3'd4) begin
      errors++; $display("FAIL reset_preload: ov=%b sel=%0d want 1/4", ov8, os8);
    end
    @(negedge clk);
    ordy8 = 1'b1;
    #3 reset = 1'b1;
    #1;
    checks++; if (ov8 !== 1'b0 || os8 !== 3'd0 || r8 !== 8'h00 || ptr8 !== 3'd0) begin
      errors++; $display("FAIL reset_async: ov=%b sel=%0d rdy=%h ptr=%0d want 0/0/00/0", ov8, os8, r8, ptr8);
    end
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    v8 = 8'b0100_1000;
    w = $urandom; d8[3*32 +: 32] = w;
    #1;
    checks++; if (r8 !== 8'h08) begin
      errors++; $display("FAIL reset_first_ready: got %h want 08", r8);
    end
    tick();
    checks++; if (os8 !== 3'd3 || od8 !== w || ov8 !== 1'b1) begin
      errors++; $display("FAIL reset_first_grant: sel=%0d data=%h want 3/%h", os8, od8, w);
    end
    @(negedge clk);
    v8 = '0;
  endtask

  task automatic test_rotation();
    do_reset();
    for (int i = 0; i < 8; i++) d8[i*32 +: 32] = 32'hA000_0000 + i;
    v8 = 8'hFF; ordy8 = 1'b1;
    for (int c = 0; c < 9; c++) begin
      #1;
      checks++; if (r8 !== (8'd1 << (c % 8))) begin
        errors++; $display("FAIL rotation_ready[%0d]: got %h want %h", c, r8, 8'd1 << (c % 8));
      end
      tick();
      checks++; if (ov8 !== 1'b1 || os8 !== 3'(c % 8) || od8 !== 32'hA000_0000 + 32'(c % 8)) begin
        errors++; $display("FAIL rotation_out[%0d]: ov=%b sel=%0d data=%h want sel %0d", c, ov8, os8, od8, c % 8);
      end
      @(negedge clk);
    end
    v8 = '0;
  endtask

  task automatic test_backpressure();
    logic [31:0] w2, w5;
    do_reset();
    w2 = $urandom; w5 = $urandom;
    d8[2*32 +: 32] = w2; d8[5*32 +: 32] = w5;
    v8 = 8'h24; ordy8 = 1'b1;
    #1;
    checks++; if (r8 !== 8'h04) begin
      errors++; $display("FAIL bp_first_ready: got %h want 04", r8);
    end
    tick();
    checks++; if (os8 !== 3'd2 || od8 !== w2) begin
      errors++; $display("FAIL bp_first_load: sel=%0d data=%h want 2/%h", os8, od8, w2);
    end
    @(negedge clk);
    v8 = 8'h20; ordy8 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (r8 !== 8'h00) begin
        errors++; $display("FAIL bp_ready_low[%0d]: got %h want 00", c, r8);
      end
      tick();
      checks++; if (ov8 !== 1'b1 || os8 !== 3'd2 || od8 !== w2) begin
        errors++; $display("FAIL bp_hold[%0d]: ov=%b sel=%0d data=%h want 1/2/%h", c, ov8, os8, od8, w2);
      end
      @(negedge clk);
    end
    ordy8 = 1'b1;
    #1;
    checks++; if (r8 !== 8'h20) begin
      errors++; $display("FAIL bp_release_ready: got %h want 20", r8);
    end
    tick();
    checks++; if (ov8 !== 1'b1 || os8 !== 3'd5 || od8 !== w5) begin
      errors++; $display("FAIL bp_release_load: sel=%0d data=%h want 5/%h", os8, od8, w5);
    end
    @(negedge clk);
    v8 = '0;
  endtask

  task automatic test_sparse_wrap();
    do_reset();
    ordy8 = 1'b1; v8 = 8'h20;
    tick();
    checks++; if (ptr8 !== 3'd6) begin
      errors++; $display("FAIL wrap_setup_ptr: got %0d want 6", ptr8);
    end
    @(negedge clk);
    v8 = 8'h02;
    #1;
    checks++; if (r8 !== 8'h02) begin
      errors++; $display("FAIL wrap_ready_ch1: got %h want 02", r8);
    end
    tick();
    checks++; if (os8 !== 3'd1 || ptr8 !== 3'd2) begin
      errors++; $display("FAIL wrap_grant_ch1: sel=%0d ptr=%0d want 1/2", os8, ptr8);
    end
    @(negedge clk);
    v8 = 8'h80;
    tick();
    checks++; if (os8 !== 3'd7 || ptr8 !== 3'd0) begin
      errors++; $display("FAIL wrap_grant_ch7: sel=%0d ptr=%0d want 7/0", os8, ptr8);
    end
    @(negedge clk);
    v8 = '0;
  endtask

  task automatic test_fixed_priority();
    logic [31:0] w0, w3;
    do_reset();
    w0 = $urandom; w3 = $urandom;
    df[0 +: 32] = w0; df[3*32 +: 32] = w3;
    vf = 8'h09; ordyf = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++; if (rf !== 8'h01) begin
        errors++; $display("FAIL prio_ready[%0d]: got %h want 01", c, rf);
      end
      tick();
      checks++; if (ovf !== 1'b1 || osf !== 3'd0 || odf !== w0) begin
        errors++; $display("FAIL prio_grant0[%0d]: sel=%0d data=%h want 0/%h", c, osf, odf, w0);
      end
      @(negedge clk);
    end
    vf = 8'h08;
    tick();
    checks++; if (osf !== 3'd3 || odf !== w3) begin
      errors++; $display("FAIL prio_grant3: sel=%0d data=%h want 3/%h", osf, odf, w3);
    end
    @(negedge clk);
    vf = '0;
  endtask

  task automatic test_non_pow2();
    do_reset();
    for (int i = 0; i < 5; i++) d5[i*32 +: 32] = $urandom;
    v5 = 5'h1F; ordy5 = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++; if (os5 !== 3'(c % 5) || od5 !== d5[(c % 5)*32 +: 32]) begin
        errors++; $display("FAIL np2_seq[%0d]: sel=%0d data=%h want sel %0d", c, os5, od5, c % 5);
      end
      checks++; if (ptr5 >= 3'd5 || ptr5 !== 3'((c + 1) % 5)) begin
        errors++; $display("FAIL np2_ptr[%0d]: got %0d want %0d", c, ptr5, (c + 1) % 5);
      end
      @(negedge clk);
    end
    v5 = '0;
    tick();
    checks++; if (ov5 !== 1'b0 || os5 !== 3'd0) begin
      errors++; $display("FAIL np2_drain: ov=%b sel=%0d want 0/0", ov5, os5);
    end
  endtask

  task automatic test_random();
    logic [31:0] e;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      // producers hold a pending word until it is taken
      for (int i = 0; i < 8; i++) begin
        if (!(v8[i] && !acc8[i])) begin v8[i] = 1'($urandom_range(0, 1)); d8[i*32 +: 32] = $urandom; end
        if (!(vf[i] && !accf[i])) begin vf[i] = 1'($urandom_range(0, 1)); df[i*32 +: 32] = $urandom; end
      end
      for (int i = 0; i < 5; i++) begin
        if (!(v5[i] && !acc5[i])) begin v5[i] = 1'($urandom_range(0, 1)); d5[i*32 +: 32] = $urandom; end
      end
      ordy8 = ($urandom_range(0, 3) != 0);
      ordyf = ($urandom_range(0, 3) != 0);
      ordy5 = ($urandom_range(0, 3) != 0);
      #1;
      e = exp_rdy(0, 8, m_ptr8, {24'b0, v8}, m_ov8, ordy8, 1'b0);
      checks++; if ({24'b0, r8} !== e) begin
        errors++; $display("FAIL rand_rr8_ready[%0d]: got %h want %h", c, r8, e);
      end
      e = exp_rdy(1, 8, 0, {24'b0, vf}, m_ovf, ordyf, 1'b0);
      checks++; if ({24'b0, rf} !== e) begin
        errors++; $display("FAIL rand_fp8_ready[%0d]: got %h want %h", c, rf, e);
      end
      e = exp_rdy(0, 5, m_ptr5, {27'b0, v5}, m_ov5, ordy5, 1'b0);
      checks++; if ({27'b0, r5} !== e) begin
        errors++; $display("FAIL rand_rr5_ready[%0d]: got %h want %h", c, r5, e);
      end
      tick();
      checks++; if (ov8 !== m_ov8 || od8 !== m_od8 || os8 !== 3'(m_os8) || ptr8 !== 3'(m_ptr8)) begin
        errors++; $display("FAIL rand_rr8_out[%0d]: ov=%b d=%h s=%0d p=%0d want %b %h %0d %0d",
                           c, ov8, od8, os8, ptr8, m_ov8, m_od8, m_os8, m_ptr8);
      end
      checks++; if (ovf !== m_ovf || odf !== m_odf || osf !== 3'(m_osf) || ptrf !== 3'd0) begin
        errors++; $display("FAIL rand_fp8_out[%0d]: ov=%b d=%h s=%0d p=%0d want %b %h %0d 0",
                           c, ovf, odf, osf, ptrf, m_ovf, m_odf, m_osf);
      end
      checks++; if (ov5 !== m_ov5 || od5 !== m_od5 || os5 !== 3'(m_os5) || ptr5 !== 3'(m_ptr5)) begin
        errors++; $display("FAIL rand_rr5_out[%0d]: ov=%b d=%h s=%0d p=%0d want %b %h %0d %0d",
                           c, ov5, od5, os5, ptr5, m_ov5, m_od5, m_os5, m_ptr5);
      end
      @(negedge clk);
    end
    v8 = '0; vf = '0; v5 = '0;
  endtask

  initial begin
    reset = 1'b1;
    v8 = '0; vf = '0; v5 = '0;
    d8 = '0; df = '0; d5 = '0;
    ordy8 = 1'b1; ordyf = 1'b1; ordy5 = 1'b1;
    model_clear();
    test_reset();
    test_rotation();
    test_backpressure();
    test_sparse_wrap();
    test_fixed_priority();
    test_non_pow2();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
